// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM encoding, stage indices
// and counter widths.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_ENTER = 2'd2
   } state_t;

   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;
   localparam int NUM_STAGES = STG_WB + 1;

   localparam int DRAIN_CNT_W = 4;
   localparam int WDOG_CNT_W  = 16;

endpackage

// File: rtl/pipeline_ctrl_stall_wdog.sv
// Stall watchdog: counts consecutive stalled cycles and raises a sticky
// timeout once the count reaches WDOG_LIMIT (saturating 16-bit counter).
module stall_wdog
   import pipeline_ctrl_pkg::*;
#(
   parameter int WDOG_LIMIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic stall_in,
   output logic timeout
);

   logic [WDOG_CNT_W-1:0] cnt;
   logic [WDOG_CNT_W-1:0] cnt_inc;

   assign cnt_inc = (cnt == '1) ? cnt : cnt + WDOG_CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         cnt <= stall_in ? cnt_inc : '0;
         if (stall_in && (cnt_inc >= WDOG_CNT_W'(WDOG_LIMIT)))
            timeout <= 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/redirect/interrupt-entry controller.
// Optional stall watchdog is built when PIPELINE_CTRL_WDOG_EN is defined.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int DRAIN_CYCLES = 3,
   parameter int WDOG_LIMIT   = 1024
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            hold_id,
   input  logic            hold_div,
   input  logic            hold_mem,
   input  logic            jump_req,
   input  logic [XLEN-1:0] jump_addr,
   input  logic            irq_req,
   input  logic [XLEN-1:0] irq_vec,
   output logic [4:0]      stall,
   output logic [4:0]      flush,
   output logic            redir_valid,
   output logic [XLEN-1:0] redir_addr,
   output logic            irq_ack,
   output logic            wdog_timeout
);

   localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES);

   // Reject out-of-range parameters at elaboration.
   if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
      $error("pipeline_ctrl: DRAIN_CYCLES must be 1..15");
   end
   if (WDOG_LIMIT < 2 || WDOG_LIMIT > 65535) begin : g_bad_wdog
      $error("pipeline_ctrl: WDOG_LIMIT must be 2..65535");
   end

   state_t                 state, state_nxt;
   logic [DRAIN_CNT_W-1:0] cnt, cnt_nxt;
   logic [NUM_STAGES-1:0]  stall_c, flush_c;
   logic                   redir_valid_c;
   logic [XLEN-1:0]        redir_addr_c;
   logic                   jump_go;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= ST_RUN;
         cnt     <= '0;
         irq_ack <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         irq_ack <= (state == ST_ENTER);
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      stall_c       = '0;
      flush_c       = '0;
      redir_valid_c = 1'b0;
      redir_addr_c  = '0;
      jump_go       = 1'b0;

      case (state)
         ST_RUN, ST_DRAIN: begin
            // A jump seen under a mem/div hold waits until the hold drops.
            jump_go = jump_req & ~hold_mem & ~hold_div;
            if (hold_mem) begin
               stall_c[STG_MEM:STG_IF] = '1;
            end else if (hold_div) begin
               stall_c[STG_EX:STG_IF] = '1;
               flush_c[STG_MEM]       = 1'b1;
            end else if (jump_req) begin
               flush_c[STG_EX:STG_ID] = '1;
               redir_valid_c          = 1'b1;
               redir_addr_c           = jump_addr;
            end else if (hold_id) begin
               stall_c[STG_ID:STG_IF] = '1;
               flush_c[STG_EX]        = 1'b1;
            end

            if (state == ST_RUN) begin
               if (irq_req && !jump_go) begin
                  state_nxt = ST_DRAIN;
                  cnt_nxt   = DRAIN_LOAD;
               end
            end else begin
               stall_c[STG_IF] = 1'b1;
               flush_c[STG_ID] = 1'b1;
               if (!irq_req) begin
                  state_nxt = ST_RUN;
                  cnt_nxt   = '0;
               end else if (jump_go) begin
                  cnt_nxt = DRAIN_LOAD;
               end else if (!hold_mem && !hold_div) begin
                  if (cnt <= DRAIN_CNT_W'(1)) begin
                     cnt_nxt   = '0;
                     state_nxt = ST_ENTER;
                  end else begin
                     cnt_nxt = cnt - DRAIN_CNT_W'(1);
                  end
               end
            end
         end

         ST_ENTER: begin
            flush_c[STG_MEM:STG_ID] = '1;
            redir_valid_c           = 1'b1;
            redir_addr_c            = irq_vec;
            state_nxt               = ST_RUN;
            cnt_nxt                 = '0;
         end

         default: begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
         end
      endcase

      // Hold the whole pipe while reset is applied.
      if (!rst) begin
         stall_c       = '1;
         flush_c       = '1;
         redir_valid_c = 1'b0;
      end
   end

   assign stall       = stall_c;
   assign flush       = flush_c;
   assign redir_valid = redir_valid_c;
   assign redir_addr  = redir_addr_c;

`ifdef PIPELINE_CTRL_WDOG_EN
   stall_wdog #(
      .WDOG_LIMIT(WDOG_LIMIT)
   ) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .stall_in (stall[STG_IF]),
      .timeout  (wdog_timeout)
   );
`else
   assign wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: stall/flush vector table plus interrupt,
// reset and watchdog sequences.
module tb_pipeline_ctrl;

   logic        clk;
   logic        rst;
   logic        hold_id, hold_div, hold_mem;
   logic        jump_req;
   logic [31:0] jump_addr;
   logic        irq_req;
   logic [31:0] irq_vec;
   logic [4:0]  stall, flush;
   logic        redir_valid;
   logic [31:0] redir_addr;
   logic        irq_ack;
   logic        wdog_timeout;

   int checks = 0;
   int errors = 0;

   pipeline_ctrl #(
      .XLEN(32),
      .DRAIN_CYCLES(3),
      .WDOG_LIMIT(8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .hold_id      (hold_id),
      .hold_div     (hold_div),
      .hold_mem     (hold_mem),
      .jump_req     (jump_req),
      .jump_addr    (jump_addr),
      .irq_req      (irq_req),
      .irq_vec      (irq_vec),
      .stall        (stall),
      .flush        (flush),
      .redir_valid  (redir_valid),
      .redir_addr   (redir_addr),
      .irq_ack      (irq_ack),
      .wdog_timeout (wdog_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled on
   // the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic        id;
      logic        dv;
      logic        mem;
      logic        jmp;
      logic [31:0] addr;
      logic [4:0]  st;
      logic [4:0]  fl;
      logic        rv;
   } vec_t;

   vec_t vecs[10];

   task automatic run_irq(input string tag, input int mem_cycles, input int jump_at,
                          input int drain_first, input int exp_ack, input bit enter_jump);
      int          ack_cycle, ack_count, enter_c;
      logic [4:0]  es, ef;
      logic        erv;
      logic [31:0] ea;
      ack_cycle = -1;
      ack_count = 0;
      enter_c   = exp_ack - 1;
      irq_vec   = 32'h0000_0040;
      for (int c = 0; c < exp_ack + 4; c++) begin
         irq_req   = (c <= enter_c);
         hold_mem  = (c >= drain_first) && (c < drain_first + mem_cycles);
         jump_req  = (c == jump_at) || (enter_jump && c == enter_c);
         jump_addr = 32'h0000_0900 + 32'(c);
         es = '0; ef = '0; erv = 1'b0; ea = '0;
         if (c == enter_c) begin
            ef = 5'b01110; erv = 1'b1; ea = 32'h0000_0040;
         end else begin
            if (hold_mem) es = 5'b01111;
            else if (jump_req) begin
               ef = 5'b00110; erv = 1'b1; ea = jump_addr;
            end
            if (c >= drain_first && c < enter_c) begin
               es[0] = 1'b1; ef[1] = 1'b1;
            end
         end
         @(negedge clk);
         check({tag, "_stall"}, 32'(stall), 32'(es));
         check({tag, "_flush"}, 32'(flush), 32'(ef));
         check({tag, "_redir_valid"}, 32'(redir_valid), 32'(erv));
         if (erv) check({tag, "_redir_addr"}, redir_addr, ea);
         if (irq_ack) begin
            ack_count++;
            if (ack_cycle < 0) ack_cycle = c;
         end
         next_cycle();
      end
      irq_req = 1'b0; hold_mem = 1'b0; jump_req = 1'b0;
      check({tag, "_ack_cycle"}, 32'(ack_cycle), 32'(exp_ack));
      check({tag, "_ack_count"}, 32'(ack_count), 32'd1);
   endtask

   initial begin
      int acks;
      rst = 1'b0;
      hold_id = 0; hold_div = 0; hold_mem = 0;
      jump_req = 0; jump_addr = '0; irq_req = 0; irq_vec = '0;

      // Reset: outputs forced, redirect suppressed even with a jump pending.
      next_cycle();
      jump_req = 1'b1; jump_addr = 32'h123; irq_req = 1'b1;
      next_cycle();
      @(negedge clk);
      check("rst_stall", 32'(stall), 32'h1f);
      check("rst_flush", 32'(flush), 32'h1f);
      check("rst_redir_valid", 32'(redir_valid), 32'd0);
      check("rst_irq_ack", 32'(irq_ack), 32'd0);
      check("rst_wdog", 32'(wdog_timeout), 32'd0);
      next_cycle();
      rst = 1'b1; jump_req = 1'b0; irq_req = 1'b0;

      //              id dv mem jmp addr          stall     flush     rv
      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   5'b00000, 5'b00000, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   5'b00011, 5'b00100, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   5'b01111, 5'b00000, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   5'b00111, 5'b01000, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   5'b00111, 5'b01000, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   5'b01111, 5'b00000, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 5'b00000, 5'b00110, 1'b1};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h2000_0004, 5'b00000, 5'b00110, 1'b1};
      vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 5'b00111, 5'b01000, 1'b0};
      vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 5'b01111, 5'b00000, 1'b0};

      for (int i = 0; i < 10; i++) begin
         hold_id = vecs[i].id; hold_div = vecs[i].dv; hold_mem = vecs[i].mem;
         jump_req = vecs[i].jmp; jump_addr = vecs[i].addr;
         @(negedge clk);
         check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].st));
         check($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].fl));
         check($sformatf("vec%0d_redir_valid", i), 32'(redir_valid), 32'(vecs[i].rv));
         if (vecs[i].rv) check($sformatf("vec%0d_redir_addr", i), redir_addr, vecs[i].addr);
         next_cycle();
      end
      hold_id = 0; hold_div = 0; hold_mem = 0; jump_req = 0;
      next_cycle();

      run_irq("irq_base", 0, -1, 1, 5, 1'b0);
      run_irq("irq_mem2", 2, -1, 1, 7, 1'b0);
      run_irq("irq_jmp_drain", 0, 2, 1, 7, 1'b0);
      run_irq("irq_jmp_run", 0, 0, 2, 6, 1'b0);
      run_irq("irq_enter_jmp", 0, -1, 1, 5, 1'b1);

      // irq_req drops mid-drain: back to RUN, no ack.
      acks = 0;
      irq_vec = 32'h40;
      for (int c = 0; c < 12; c++) begin
         irq_req = (c < 2);
         @(negedge clk);
         if (c == 2) check("irqdrop_drain_stall", 32'(stall), 32'b00001);
         if (c == 3) check("irqdrop_run_stall", 32'(stall), 32'b00000);
         if (irq_ack) acks++;
         next_cycle();
      end
      check("irqdrop_ack_count", 32'(acks), 32'd0);

      // Reset applied in ENTER: no ack.
      acks = 0;
      for (int c = 0; c < 12; c++) begin
         irq_req = (c < 5);
         rst = (c != 4);
         @(negedge clk);
         if (c == 4) begin
            check("rst_enter_redir_valid", 32'(redir_valid), 32'd0);
            check("rst_enter_stall", 32'(stall), 32'h1f);
         end
         if (irq_ack) acks++;
         next_cycle();
      end
      rst = 1'b1; irq_req = 1'b0;
      check("rst_enter_ack_count", 32'(acks), 32'd0);

`ifdef PIPELINE_CTRL_WDOG_EN
      // Broken stall runs shorter than the limit never time out.
      for (int c = 0; c < 11; c++) begin
         hold_div = (c != 5);
         next_cycle();
      end
      hold_div = 1'b0;
      @(negedge clk);
      check("wdog_gap_no_timeout", 32'(wdog_timeout), 32'd0);
      next_cycle();
      for (int c = 0; c < 9; c++) begin
         hold_div = 1'b1;
         @(negedge clk);
         if (c == 7) check("wdog_before_limit", 32'(wdog_timeout), 32'd0);
         if (c == 8) check("wdog_at_limit", 32'(wdog_timeout), 32'd1);
         next_cycle();
      end
      hold_div = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("wdog_sticky", 32'(wdog_timeout), 32'd1);
         next_cycle();
      end
      rst = 1'b0;
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      check("wdog_cleared_by_rst", 32'(wdog_timeout), 32'd0);
      next_cycle();
`else
      for (int c = 0; c < 12; c++) begin
         hold_div = 1'b1;
         next_cycle();
      end
      hold_div = 1'b0;
      @(negedge clk);
      check("wdog_absent_zero", 32'(wdog_timeout), 32'd0);
      next_cycle();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter XLEN, default 32, address width of redirect paths.
REQ-002 Parameter DRAIN_CYCLES, default 3, cycles to drain EX/MEM/WB before interrupt entry; legal range 1..15.
REQ-003 Parameter WDOG_LIMIT, default 1024, consecutive-stall cycles before watchdog timeout; legal range 2..65535.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 hold_id  in  1  load-use/RAW stall request from the hazard detect unit.
REQ-007 hold_div  in  1  multicycle divider busy.
REQ-008 hold_mem  in  1  data bus wait.
REQ-009 jump_req / jump_addr  in  1 / XLEN  branch or jump resolved in EX, with its target.
REQ-010 irq_req / irq_vec  in  1 / XLEN  level interrupt request, with its handler address.
REQ-011 stall  out  5  per-stage hold, bit0=IF ... bit4=WB.
REQ-012 flush  out  5  per-stage bubble insert, same bit order.
REQ-013 redir_valid / redir_addr  out  1 / XLEN  one-cycle PC redirect.
REQ-014 irq_ack  out  1  one-cycle pulse on interrupt entry.
REQ-015 wdog_timeout  out  1  sticky watchdog flag; tied 0 when the watchdog is compiled out.

Function
REQ-016 FSM states are RUN, DRAIN and ENTER; all outputs are registered, except that stall, flush and redir_* are combinational from the state and the current inputs.
REQ-017 Stall priority is hold_mem > hold_div > hold_id.
- hold_mem: stall[3:0]=1.
- hold_div: stall[2:0]=1, flush[3]=1.
- hold_id: stall[1:0]=1, flush[2]=1.
REQ-018 jump_req in RUN or DRAIN without hold_mem/hold_div:
- redir_valid=1, redir_addr=jump_addr.
- flush[2:1]=1; this overrides the hold_id stall in the same cycle.
REQ-019 A jump_req coincident with hold_mem or hold_div is held off and takes effect in the first cycle the holds drop; jump_req is required to stay asserted until then.
REQ-020 RUN -> DRAIN when irq_req=1 and no redirect is issued that cycle.
- The drain counter loads DRAIN_CYCLES.
REQ-021 DRAIN behaviour:
- stall[0]=1 and flush[1]=1 every cycle.
- The counter decrements by 1 per cycle while hold_mem=0 and hold_div=0, and is frozen otherwise.
- A redirect issued in DRAIN reloads the counter to DRAIN_CYCLES.
REQ-022 DRAIN -> ENTER when the counter reaches 0.
REQ-023 DRAIN -> RUN with no ack if irq_req drops before the counter reaches 0.
REQ-024 ENTER lasts exactly one cycle:
- redir_valid=1, redir_addr=irq_vec, flush[3:1]=1, irq_ack=1 on the next edge.
- ENTER -> RUN.
REQ-025 In ENTER, jump_req is ignored; the interrupt redirect wins.
REQ-026 Latency: irq_req rising in RUN with no holds -> irq_ack pulse DRAIN_CYCLES+2 cycles later.

Reset
REQ-027 While rst=0 at a clock edge:
- state=RUN, drain counter=0, irq_ack=0, wdog_timeout=0, watchdog counter=0.
REQ-028 During reset, stall and flush are forced to 5'b11111 and redir_valid to 0.
REQ-029 Reset asserted in DRAIN or ENTER abandons the interrupt entry with no ack.

Configuration
REQ-030 Macro PIPELINE_CTRL_WDOG_EN defined:
- The watchdog counter increments on every cycle where stall[0]=1 and clears on any cycle where stall[0]=0.
- wdog_timeout sets when the count reaches WDOG_LIMIT and holds until reset.
- Counter width is 16 bits and the counter saturates.
REQ-031 Macro undefined: no watchdog logic is present and wdog_timeout is constant 0.

Structure
REQ-032 Package pipeline_ctrl_pkg holds the FSM state encoding, the stage index constants (IF=0..WB=4) and the counter widths.
REQ-033 The watchdog is sub-module stall_wdog (clk, rst, stall_in, timeout), instantiated only under PIPELINE_CTRL_WDOG_EN.

Verification
REQ-034 The bench covers these directed scenarios:
- hold_id=1 for 1 cycle: stall=00011, flush=00100, redir_valid=0.
- hold_mem=1 together with hold_id=1: stall=01111, flush=00000.
- jump_req=1, jump_addr=0x0000_0100, hold_id=1: redir_valid=1, redir_addr=0x100, flush=00110, stall=00000.
- irq_req=1, irq_vec=0x0000_0040, no holds, DRAIN_CYCLES=3: DRAIN for 3 cycles, then ENTER with redir_addr=0x40, flush=01110, and irq_ack pulses exactly once, 5 cycles after the request.
- irq_req=1 with hold_mem=1 for 2 drain cycles: irq_ack is delayed by exactly 2 cycles relative to the previous scenario.
- With PIPELINE_CTRL_WDOG_EN and WDOG_LIMIT=8, hold_div=1 continuously: wdog_timeout=1 after the 8th stall cycle and stays 1 after hold_div drops, until rst=0.
